// File: rtl/uart_arb_pkg.sv
// Shared types, default parameters and helpers for the UART transmit arbiter.
package uart_arb_pkg;

  // ARB searches for the next requester. STREAM forwards bytes from the granted lane.
  typedef enum logic {
    ARB    = 1'b0,
    STREAM = 1'b1
  } arb_state_e;

  localparam int NREQ_DEF      = 4;
  localparam int MAX_BURST_DEF = 16;

  // Returns the index after idx, wrapping to zero at n.
  function automatic logic [31:0] rr_next(input logic [31:0] idx, input logic [31:0] n);
    logic [31:0] nxt;
    if (idx + 32'd1 >= n) begin
      nxt = 32'd0;
    end else begin
      nxt = idx + 32'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/uart_rr_picker.sv
// Round-robin picker. It rotates the request vector so that rr_ptr lands
// at bit 0, takes the lowest set bit, and then rotates the index back.
module uart_rr_picker
  import uart_arb_pkg::*;
#(
  parameter int NREQ = NREQ_DEF
) (
  input  logic [NREQ-1:0]         i_req,
  input  logic [$clog2(NREQ)-1:0] i_rr_ptr,
  output logic                    o_found,
  output logic [$clog2(NREQ)-1:0] o_idx
);

  localparam int IW = $clog2(NREQ);

  logic [NREQ-1:0] w_rot;
  logic [IW-1:0]   w_k;
  logic [IW-1:0]   w_pos;
  logic            w_any;

  // Rotate the requests so that the requester at rr_ptr lands at position 0.
  always_comb begin
    w_rot = '0;
    w_k   = '0;
    for (int j = 0; j < NREQ; j++) begin
      w_k      = IW'((j + int'(i_rr_ptr)) % NREQ);
      w_rot[j] = i_req[w_k];
    end
  end

  // Priority-encode the lowest set bit of the rotated vector.
  always_comb begin
    w_any = 1'b0;
    w_pos = '0;
    for (int j = NREQ - 1; j >= 0; j--) begin
      if (w_rot[j]) begin
        w_any = 1'b1;
        w_pos = IW'(j);
      end else begin
        w_pos = w_pos;
      end
    end
  end

  // Un-rotate the winning position back into a requester index.
  always_comb begin
    o_found = w_any;
    o_idx   = IW'((int'(w_pos) + int'(i_rr_ptr)) % NREQ);
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART TX FIFO among NREQ byte streams.
// A grant is held for a whole message. It ends on req_last, or earlier
// when MAX_BURST bytes have been taken. Accepted bytes go straight into
// the FIFO in the same cycle.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NREQ      = NREQ_DEF,
  parameter int DBIT      = 8,
  parameter int MAX_BURST = MAX_BURST_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*DBIT-1:0]    req_data,
  input  logic [NREQ-1:0]         req_last,
  output logic [NREQ-1:0]         req_ready,
  input  logic                    tx_full,
  output logic                    wr_uart,
  output logic [DBIT-1:0]         w_data,
  output logic [$clog2(NREQ)-1:0] grant_id,
  output logic                    busy
);

  localparam int GW = $clog2(NREQ);
  localparam int CW = $clog2(MAX_BURST + 1);

  arb_state_e      r_state;
  arb_state_e      w_next_state;
  logic [GW-1:0]   r_rr_ptr;
  logic [GW-1:0]   w_next_rr_ptr;
  logic [GW-1:0]   r_grant_id;
  logic [GW-1:0]   w_next_grant_id;
  logic [CW-1:0]   r_burst_cnt;
  logic [CW-1:0]   w_next_burst_cnt;

  logic            w_found;
  logic [GW-1:0]   w_pick;
  logic [DBIT-1:0] w_lane;
  logic            w_accept;
  logic            w_release;

  uart_rr_picker #(
    .NREQ (NREQ)
  ) u_picker (
    .i_req    (req_valid),
    .i_rr_ptr (r_rr_ptr),
    .o_found  (w_found),
    .o_idx    (w_pick)
  );

  // Select the granted lane, decide on acceptance, and drive the FIFO write port.
  always_comb begin
    w_lane    = '0;
    w_accept  = 1'b0;
    w_release = 1'b0;
    wr_uart   = 1'b0;
    w_data    = '0;
    req_ready = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_lane = w_lane | (req_data[i*DBIT +: DBIT] & {DBIT{r_grant_id == GW'(i)}});
    end
    if (r_state == STREAM) begin
      w_accept  = req_valid[r_grant_id] & ~tx_full;
      // A byte that is both last and at the burst limit gives one release.
      w_release = w_accept & (req_last[r_grant_id] | (r_burst_cnt == CW'(MAX_BURST - 1)));
      w_data    = w_lane;
    end else begin
      w_accept  = 1'b0;
      w_release = 1'b0;
      w_data    = '0;
    end
    wr_uart = w_accept;
    for (int i = 0; i < NREQ; i++) begin
      req_ready[i] = w_accept & (r_grant_id == GW'(i));
    end
  end

  // Next-state logic: pick a requester in ARB; count bytes and release in STREAM.
  always_comb begin
    w_next_state     = r_state;
    w_next_rr_ptr    = r_rr_ptr;
    w_next_grant_id  = r_grant_id;
    w_next_burst_cnt = r_burst_cnt;
    case (r_state)
      ARB: begin
        if (w_found) begin
          w_next_state     = STREAM;
          w_next_grant_id  = w_pick;
          w_next_burst_cnt = '0;
        end else begin
          w_next_state = ARB;
        end
      end
      STREAM: begin
        if (w_release) begin
          w_next_state     = ARB;
          w_next_rr_ptr    = GW'(rr_next(32'(r_grant_id), 32'(NREQ)));
          w_next_burst_cnt = '0;
        end else if (w_accept) begin
          w_next_burst_cnt = r_burst_cnt + CW'(1);
        end else begin
          w_next_state = STREAM;
        end
      end
      default: begin
        w_next_state = ARB;
      end
    endcase
  end

  // State register. Reset returns the arbiter to idle and takes priority over everything else.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ARB;
      r_rr_ptr    <= '0;
      r_grant_id  <= '0;
      r_burst_cnt <= '0;
    end else begin
      r_state     <= w_next_state;
      r_rr_ptr    <= w_next_rr_ptr;
      r_grant_id  <= w_next_grant_id;
      r_burst_cnt <= w_next_burst_cnt;
    end
  end

  assign grant_id = r_grant_id;
  assign busy     = (r_state == STREAM);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter. Requester queues feed the DUT.
// A message-level reference model predicts every cycle. Directed phases
// and a randomized phase drive the design.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;

  localparam int NREQ      = 4;
  localparam int DBIT      = 8;
  localparam int MAX_BURST = 4;
  localparam int GW        = 2;
  localparam int QD        = 1024;
  localparam int LD        = 16384;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ*DBIT-1:0] req_data;
  logic [NREQ-1:0]      req_last;
  logic [NREQ-1:0]      req_ready;
  logic                 tx_full;
  logic                 wr_uart;
  logic [DBIT-1:0]      w_data;
  logic [GW-1:0]        grant_id;
  logic                 busy;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NREQ(NREQ), .DBIT(DBIT), .MAX_BURST(MAX_BURST)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .tx_full(tx_full),
    .wr_uart(wr_uart), .w_data(w_data), .grant_id(grant_id), .busy(busy)
  );

  // Requester queues: each entry is {last, data}.
  logic [8:0] qmem [NREQ][QD];
  int         qhd [NREQ];
  int         qtl [NREQ];

  // Log of the bytes the DUT writes: data, source lane and cycle.
  logic [7:0] lg_dat [LD];
  int         lg_src [LD];
  int         lg_cyc [LD];
  int         wn = 0;

  // Reference model state.
  int m_owner = -1;
  int m_next  = 0;
  int m_gid   = 0;
  int m_sent  = 0;

  // Stimulus controls.
  bit rst_req   = 1'b0;
  bit rand_mode = 1'b0;
  int full_hold = 0;
  int full_pct  = 0;
  int drop_pct  = 0;
  int drop_cnt [NREQ];
  int cyc       = 0;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
  endtask

  task automatic push(input int i, input logic [7:0] d, input logic l);
    qmem[i][qtl[i] % QD] = {l, d};
    qtl[i]++;
  endtask

  // One clock: drive the inputs, compare the outputs with the model, then advance the model.
  task automatic step();
    logic [8:0]      h;
    bit              v;
    bit              lst;
    int              src;
    logic [NREQ-1:0] e_ready;
    logic            e_wr;
    logic [7:0]      e_data;
    @(posedge clk); #1;
    reset = rst_req;
    for (int i = 0; i < NREQ; i++) begin
      h = (qtl[i] > qhd[i]) ? qmem[i][qhd[i] % QD] : 9'h000;
      v = (qtl[i] > qhd[i]) && (drop_cnt[i] == 0) && !rst_req;
      if (rand_mode && ($urandom_range(0, 99) < drop_pct)) v = 1'b0;
      req_valid[i]              = v;
      req_last[i]               = v ? h[8] : 1'b0;
      req_data[i*DBIT +: DBIT]  = h[7:0];
      if (drop_cnt[i] > 0) drop_cnt[i]--;
    end
    tx_full = (full_hold > 0) || (rand_mode && ($urandom_range(0, 99) < full_pct));
    if (full_hold > 0) full_hold--;
    @(negedge clk);
    e_ready = '0;
    e_wr    = 1'b0;
    e_data  = 8'h00;
    if (m_owner >= 0) begin
      e_data = (qtl[m_owner] > qhd[m_owner]) ? qmem[m_owner][qhd[m_owner] % QD][7:0] : 8'h00;
      if (req_valid[m_owner] && !tx_full) begin
        e_ready[m_owner] = 1'b1;
        e_wr             = 1'b1;
      end
    end
    check("busy",      32'(busy),      32'(m_owner >= 0));
    check("grant_id",  32'(grant_id),  32'(m_gid));
    check("wr_uart",   32'(wr_uart),   32'(e_wr));
    check("w_data",    32'(w_data),    32'(e_data));
    check("req_ready", 32'(req_ready), 32'(e_ready));
    if (wr_uart === 1'b1 && wn < LD) begin
      src = -1;
      for (int i = 0; i < NREQ; i++) if (req_ready[i] === 1'b1) src = i;
      lg_dat[wn] = w_data;
      lg_src[wn] = src;
      lg_cyc[wn] = cyc;
      wn++;
    end
    if (reset) begin
      m_owner = -1; m_next = 0; m_gid = 0; m_sent = 0;
    end else if (m_owner < 0) begin
      for (int o = 0; o < NREQ; o++) begin
        if (m_owner < 0 && req_valid[(m_next + o) % NREQ]) begin
          m_owner = (m_next + o) % NREQ;
          m_gid   = m_owner;
          m_sent  = 0;
        end
      end
    end else if (e_wr) begin
      lst = qmem[m_owner][qhd[m_owner] % QD][8];
      qhd[m_owner]++;
      m_sent++;
      if (lst || m_sent == MAX_BURST) begin
        m_next  = (m_owner + 1) % NREQ;
        m_owner = -1;
      end
    end
    cyc++;
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic do_reset();
    for (int i = 0; i < NREQ; i++) begin qhd[i] = qtl[i]; drop_cnt[i] = 0; end
    full_hold = 0;
    rst_req = 1'b1; step();
    rst_req = 1'b0; step();
  endtask

  task automatic wait_writes(input int target, input int budget);
    int b;
    b = 0;
    while (wn < target && b < budget) begin step(); b++; end
    if (wn < target) check("wait_writes_timeout", 32'(wn), 32'(target));
  endtask

  task automatic expect_log(input string tag, input int s, input int k,
                            input logic [7:0] d, input int src);
    check({tag, "_data"}, 32'(lg_dat[s + k]), 32'(d));
    check({tag, "_src"},  32'(lg_src[s + k]), 32'(src));
  endtask

  initial begin
    int s;
    int c0;
    int len;
    logic [7:0] d3 [4];
    logic [7:0] d4 [8];
    int         s4 [8];
    for (int i = 0; i < NREQ; i++) begin qhd[i] = 0; qtl[i] = 0; drop_cnt[i] = 0; end
    reset = 1'b1; req_valid = '0; req_data = '0; req_last = '0; tx_full = 1'b0;
    repeat (2) @(posedge clk);

    // Reset state
    step();
    check("rst_busy",     32'(busy),      32'd0);
    check("rst_grant_id", 32'(grant_id),  32'd0);
    check("rst_wr_uart",  32'(wr_uart),   32'd0);
    check("rst_ready",    32'(req_ready), 32'd0);

    // Req0 sends a 3-byte message. The writes follow one cycle after valid.
    do_reset();
    s = wn;
    push(0, 8'h41, 1'b0); push(0, 8'h42, 1'b0); push(0, 8'h43, 1'b1);
    c0 = cyc;
    run(6);
    check("p1_count", 32'(wn - s), 32'd3);
    d3[0] = 8'h41; d3[1] = 8'h42; d3[2] = 8'h43;
    for (int k = 0; k < 3; k++) begin
      expect_log("p1", s, k, d3[k], 0);
      check("p1_cycle", 32'(lg_cyc[s + k]), 32'(c0 + 1 + k));
    end
    // rr_ptr is now 1, so req1 wins over req0.
    s = wn;
    push(0, 8'h55, 1'b1); push(1, 8'h66, 1'b1);
    run(8);
    check("p1b_count", 32'(wn - s), 32'd2);
    expect_log("p1b0", s, 0, 8'h66, 1);
    expect_log("p1b1", s, 1, 8'h55, 0);

    // Req1 and req2 compete. Req1 goes first, then one bubble, then req2.
    do_reset();
    s = wn;
    push(1, 8'hA0, 1'b0); push(1, 8'hA1, 1'b1);
    push(2, 8'hB0, 1'b0); push(2, 8'hB1, 1'b1);
    c0 = cyc;
    run(10);
    check("p2_count", 32'(wn - s), 32'd4);
    expect_log("p2_0", s, 0, 8'hA0, 1); check("p2_c0", 32'(lg_cyc[s]),     32'(c0 + 1));
    expect_log("p2_1", s, 1, 8'hA1, 1); check("p2_c1", 32'(lg_cyc[s + 1]), 32'(c0 + 2));
    expect_log("p2_2", s, 2, 8'hB0, 2); check("p2_c2", 32'(lg_cyc[s + 2]), 32'(c0 + 4));
    expect_log("p2_3", s, 3, 8'hB1, 2); check("p2_c3", 32'(lg_cyc[s + 3]), 32'(c0 + 5));

    // tx_full is held high for 5 cycles after the 2nd byte.
    do_reset();
    s = wn;
    for (int k = 0; k < 4; k++) push(0, 8'(8'h10 + k), k == 3);
    wait_writes(s + 2, 10);
    full_hold = 5;
    run(15);
    check("p3_count", 32'(wn - s), 32'd4);
    for (int k = 0; k < 4; k++) expect_log("p3", s, k, 8'(8'h10 + k), 0);
    check("p3_gap", 32'(lg_cyc[s + 2] - lg_cyc[s + 1]), 32'd6);

    // Burst limit of 4 forces req0 to give way to req3 partway through its message.
    do_reset();
    s = wn;
    for (int k = 0; k < 6; k++) push(0, 8'(8'h20 + k), k == 5);
    push(3, 8'h30, 1'b0); push(3, 8'h31, 1'b1);
    run(20);
    d4[0] = 8'h20; d4[1] = 8'h21; d4[2] = 8'h22; d4[3] = 8'h23;
    d4[4] = 8'h30; d4[5] = 8'h31; d4[6] = 8'h24; d4[7] = 8'h25;
    s4[0] = 0; s4[1] = 0; s4[2] = 0; s4[3] = 0; s4[4] = 3; s4[5] = 3; s4[6] = 0; s4[7] = 0;
    check("p4_count", 32'(wn - s), 32'd8);
    for (int k = 0; k < 8; k++) expect_log("p4", s, k, d4[k], s4[k]);

    // Reset is pulsed in the middle of a req2 message.
    do_reset();
    s = wn;
    for (int k = 0; k < 5; k++) push(2, 8'(8'h40 + k), k == 4);
    wait_writes(s + 2, 10);
    rst_req = 1'b1; step(); rst_req = 1'b0;
    push(1, 8'h50, 1'b1);
    step();
    check("p5_busy",     32'(busy),     32'd0);
    check("p5_grant_id", 32'(grant_id), 32'd0);
    check("p5_wr_uart",  32'(wr_uart),  32'd0);
    s = wn;
    run(12);
    check("p5_count", 32'(wn - s), 32'd4);
    expect_log("p5_0", s, 0, 8'h50, 1);
    for (int k = 1; k < 4; k++) expect_log("p5", s, k, 8'(8'h41 + k), 2);

    // Req0 drops valid mid-message while req1 waits. The grant stays on req0.
    do_reset();
    s = wn;
    for (int k = 0; k < 4; k++) push(0, 8'(8'h60 + k), k == 3);
    push(1, 8'h70, 1'b1);
    wait_writes(s + 2, 10);
    drop_cnt[0] = 3;
    run(15);
    check("p6_count", 32'(wn - s), 32'd5);
    for (int k = 0; k < 4; k++) expect_log("p6", s, k, 8'(8'h60 + k), 0);
    expect_log("p6_4", s, 4, 8'h70, 1);

    // Randomized traffic with backpressure, valid gaps and occasional resets.
    do_reset();
    rand_mode = 1'b1; full_pct = 25; drop_pct = 20;
    for (int t = 0; t < 4000; t++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (qtl[i] == qhd[i] && $urandom_range(0, 3) == 0) begin
          len = $urandom_range(1, 7);
          for (int k = 0; k < len; k++) push(i, 8'($urandom_range(0, 255)), k == len - 1);
        end
      end
      rst_req = ($urandom_range(0, 499) == 0);
      step();
    end
    rst_req = 1'b0;
    rand_mode = 1'b0;
    run(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one UART transmit path between NREQ byte-stream requesters, e.g. a command echo, a status reporter and a debug dump.
- Grants are round-robin and held for a whole message. A message ends on req_last or when the MAX_BURST limit is reached.
- Drives wr_uart/w_data straight into the uart TX FIFO and honours tx_full backpressure.
- Sits between the requester logic and the uart instance at the top level.

Parameters:
- NREQ, 4, number of requesters (2..8).
- DBIT, 8, data bits per byte; matches the uart DBIT.
- MAX_BURST, 16, maximum bytes accepted per grant before forced rotation (1..255).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  NREQ  requester i has a byte on its lane
- req_data  in  NREQ*DBIT  byte lanes; lane i = bits [i*DBIT +: DBIT]
- req_last  in  NREQ  the lane-i byte is the final byte of its message
- req_ready  out  NREQ  byte on lane i is accepted this cycle
- tx_full  in  1  uart TX FIFO full
- wr_uart  out  1  uart FIFO write strobe
- w_data  out  DBIT  uart FIFO write data
- grant_id  out  $clog2(NREQ)  currently or last granted requester
- busy  out  1  a grant is active (state STREAM)

Behaviour:
- Everything is on posedge clk. reset is synchronous and active-high and takes priority over all other logic.
- Reset values: state=ARB, rr_ptr=0, grant_id=0, burst_cnt=0, busy=0. wr_uart=0, req_ready=0 and w_data=0 follow combinationally from state ARB.
- The FSM has two states, ARB and STREAM.
- ARB:
  - Search req_valid starting at index rr_ptr, wrapping modulo NREQ.
  - First set bit k: register grant_id<=k, burst_cnt<=0, go to STREAM.
  - No bits set: stay in ARB.
  - No byte is accepted in ARB. This gives a one-cycle bubble per grant.
- STREAM handshake, g = grant_id:
  - accept = req_valid[g] & ~tx_full.
  - wr_uart = accept, w_data = lane g, req_ready[g] = accept.
  - All other req_ready bits are 0.
  - Zero latency: the byte is written in the same cycle it is accepted.
- When not streaming, w_data=0 and wr_uart=0. The FIFO is never written while tx_full=1.
- Each accept increments burst_cnt; the counter width is $clog2(MAX_BURST+1).
- Release occurs on an accept with req_last[g]=1, or on an accept where burst_cnt==MAX_BURST-1.
  - On release: next state ARB, rr_ptr <= (g+1) mod NREQ, burst_cnt <= 0.
  - A byte that is both last and at the burst limit is a single release.
- req_valid[g] dropping mid-message does not release the grant; it stalls in STREAM. There is no timeout.
- tx_full held high stalls indefinitely with no lost or duplicated bytes.
- grant_id holds its value after release until the next ARB selection.
- Requesters must hold req_data/req_last stable while req_valid=1 and not accepted. Violations are undefined and are not checked.
- Reset asserted mid-STREAM: the next cycle is in ARB with all reset values. A partially sent message is abandoned; the requester must restart it.
- Requesters that are not granted are never starved: a waiting requester is granted within (NREQ-1) grants.

Decomposition:
- Package uart_arb_pkg holds:
  - typedef enum logic {ARB, STREAM} arb_state_e;
  - constants NREQ_DEF=4 and MAX_BURST_DEF=16.
- Sub-module uart_rr_picker, purely combinational, parameter NREQ.
  - Inputs: req vector and rr_ptr.
  - Outputs: found and idx.
  - Implemented as a rotate, priority-encode and un-rotate.
- The arbiter holds the FSM, counters and datapath mux.

Test Plan:
- Req0 sends 0x41,0x42,0x43 (last on 0x43), tx_full=0.
  - First wr_uart one cycle after valid; three consecutive wr_uart with w_data 41,42,43; busy falls the cycle after 0x43; rr_ptr=1.
- Req1 and req2 both valid from reset, each with a 2-byte message (0xA0,0xA1 and 0xB0,0xB1).
  - Req1 is granted first; output is A0,A1, one bubble, then B0,B1; grant_id goes 1 then 2.
- Req0 sends 4 bytes and tx_full is forced high for 5 cycles after the 2nd byte.
  - wr_uart=0 and req_ready=0 during the stall; the byte stream continues unchanged and no byte is duplicated.
- MAX_BURST=4; req0 sends a 6-byte message while req3 is valid.
  - Req0 is released after its 4th byte; req3's message is sent; req0's remaining 2 bytes follow in a new grant.
- Reset pulsed for 1 cycle after the 2nd byte of a 5-byte req2 message.
  - The next cycle shows busy=0, grant_id=0, wr_uart=0; the first new grant follows rr_ptr=0 ordering.
- Req0 drops valid for 3 cycles mid-message while req1 is valid.
  - Grant stays on 0, req1 sees no req_ready, and req0 resumes and completes its message.
